// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_pkg;
  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/full_adder_bitwise.sv
// Single-bit full adder slice.
module full_adder_bitwise (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice walks the operands LSB-first,
// WIDTH cycles per addition, result published with a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] opa, opb, res, res_next;
  logic [CW-1:0]    cnt;
  logic             carry, sbit, cnext, last;

  full_adder_bitwise u_fa (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (carry),
    .sum  (sbit),
    .cout (cnext)
  );

  // Result register shifts right; the new sum bit enters at the MSB.
  always_comb begin
    res_next = res;
    for (int unsigned i = 1; i < WIDTH; i++) res_next[i-1] = res[i];
    res_next[WIDTH-1] = sbit;
  end

  assign last  = (cnt == CW'(WIDTH - 1));
  assign ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            carry <= cnext;
            res   <= res_next;
            cnt   <= cnt + CW'(1);
            if (last) begin
              sum   <= res_next;
              cout  <= cnext;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized bench for serial_add_ctrl (WIDTH=8 and WIDTH=1) against a
// cycle-age reference model computing sums with plain arithmetic.
module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, abort8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, done8, cout8;
  logic [7:0] sum8;
  logic       start1 = 1'b0, abort1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ready1, done1, cout1;
  logic [0:0] sum1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  bit rec_en = 1'b0;
  int done_q[$];

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8), .a(a8), .b(b8),
    .cin(cin8), .ready(ready8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .a(a1), .b(b1),
    .cin(cin1), .ready(ready1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: age = edges since accept (-1 when idle).
  int         m_age  = -1;
  logic [8:0] m_pend = '0;
  logic [7:0] m_sum  = '0;
  logic       m_cout = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age  <= -1;
      m_sum  <= '0;
      m_cout <= 1'b0;
    end else if (m_age < 0) begin
      if (start8) begin
        m_age  <= 0;
        m_pend <= 9'(a8) + 9'(b8) + 9'(cin8);
      end
    end else if (m_age == 8) begin
      m_age <= -1;
    end else if (abort8) begin
      m_age <= -1;
    end else begin
      m_age <= m_age + 1;
      if (m_age == 7) begin
        m_sum  <= m_pend[7:0];
        m_cout <= m_pend[8];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready8", 64'(ready8), 64'(m_age < 0));
      chk("done8",  64'(done8),  64'(m_age == 8));
      chk("sum8",   64'(sum8),   64'(m_sum));
      chk("cout8",  64'(cout8),  64'(m_cout));
      if (rec_en && done8) done_q.push_back(cyc);
    end
  end

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv, output int k);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic wait_done8(input int k);
    int n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done8) chk("done8_timeout", 64'd0, 64'd1);
    else        chk("done8_latency", 64'(cyc), 64'(k + 8));
  endtask

  task automatic op1(input logic av, input logic bv, input logic cv);
    int k;
    int n = 0;
    logic [1:0] e;
    e = 2'(av) + 2'(bv) + 2'(cv);
    @(negedge clk);
    a1 = av; b1 = bv; cin1 = cv; start1 = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
    a1 = ~av; b1 = ~bv;
    chk("ready1_busy", 64'(ready1), 64'd0);
    while (!done1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!done1) chk("done1_timeout", 64'd0, 64'd1);
    else begin
      chk("done1_latency", 64'(cyc), 64'(k + 1));
      chk("sum1", 64'(sum1), 64'(e[0]));
      chk("cout1", 64'(cout1), 64'(e[1]));
    end
    @(negedge clk);
    chk("done1_pulse", 64'(done1), 64'd0);
    chk("ready1_back", 64'(ready1), 64'd1);
  endtask

  initial begin
    int k;
    #1;
    chk("rst_ready8", 64'(ready8), 64'd1);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_sum8", 64'(sum8), 64'd0);
    chk("rst_cout8", 64'(cout8), 64'd0);
    chk("rst_ready1", 64'(ready1), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // 5A + 3C = 96
    op8(8'h5A, 8'h3C, 1'b0, k);
    wait_done8(k);
    chk("sum_5a3c", 64'(sum8), 64'h96);
    chk("cout_5a3c", 64'(cout8), 64'd0);
    @(negedge clk);
    chk("ready_after", 64'(ready8), 64'd1);
    chk("ready_cycle", 64'(cyc), 64'(k + 9));

    // full ripple FF + 00 + 1
    op8(8'hFF, 8'h00, 1'b1, k);
    wait_done8(k);
    chk("sum_ripple", 64'(sum8), 64'h00);
    chk("cout_ripple", 64'(cout8), 64'd1);
    @(negedge clk);

    // abort sampled at the end of the 4th RUN cycle
    op8(8'h01, 8'h01, 1'b0, k);
    repeat (3) @(negedge clk);
    abort8 = 1'b1;
    @(negedge clk);
    abort8 = 1'b0;
    chk("abort_ready", 64'(ready8), 64'd1);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_sum", 64'(sum8), 64'h00);
    chk("abort_cout", 64'(cout8), 64'd1);
    repeat (12) @(negedge clk);

    // start held high with changing operands
    rec_en = 1'b1;
    done_q.delete();
    start8 = 1'b1;
    repeat (64) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
    end
    start8 = 1'b0;
    rec_en = 1'b0;
    chk("spacing_count", 64'(done_q.size() >= 5), 64'd1);
    for (int i = 1; i < done_q.size(); i++)
      chk("done_spacing", 64'(done_q[i] - done_q[i-1]), 64'd10);
    repeat (12) @(negedge clk);

    // async reset mid-RUN
    op8(8'hA5, 8'h5A, 1'b1, k);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_ready", 64'(ready8), 64'd1);
    chk("arst_done", 64'(done8), 64'd0);
    chk("arst_sum", 64'(sum8), 64'd0);
    chk("arst_cout", 64'(cout8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(k);
    chk("sum_8080", 64'(sum8), 64'h00);
    chk("cout_8080", 64'(cout8), 64'd1);
    @(negedge clk);

    // random start/abort traffic
    repeat (400) begin
      start8 = ($urandom_range(0, 2) != 0);
      abort8 = ($urandom_range(0, 9) == 0);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
    end
    start8 = 1'b0; abort8 = 1'b0;
    repeat (12) @(negedge clk);

    // WIDTH=1
    op1(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      op1(1'($urandom), 1'($urandom), 1'($urandom));

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
